// File: rtl/collision_event_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : collision_event_arbiter
//  Description : Per-frame collision detector for NUM_OBJ drawing-request
//                layers. Every enabled object pair is reported at most once
//                per frame through a show-ahead event FIFO (valid/ready).
//                Also provides a per-frame hit summary and a first-hit pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module collision_event_arbiter #(
    parameter int NUM_OBJ    = 4,
    parameter int FIFO_DEPTH = 8,
    parameter logic [NUM_OBJ*(NUM_OBJ-1)/2-1:0] PAIR_MASK = '1
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   startOfFrame,
    input  logic [NUM_OBJ-1:0]                     drawing_request,
    output logic                                   collision,
    output logic                                   SingleHitPulse,
    output logic [NUM_OBJ*(NUM_OBJ-1)/2-1:0]       frame_hits,
    output logic                                   evt_valid,
    input  logic                                   evt_ready,
    output logic [((NUM_OBJ*(NUM_OBJ-1)/2) > 1 ? $clog2(NUM_OBJ*(NUM_OBJ-1)/2) : 1)-1:0] evt_pair,
    output logic [$clog2(NUM_OBJ)-1:0]             evt_obj_a,
    output logic [$clog2(NUM_OBJ)-1:0]             evt_obj_b,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]        evt_count
);

    localparam int c_NUM_PAIRS = NUM_OBJ * (NUM_OBJ - 1) / 2;
    localparam int c_PAIR_W    = (c_NUM_PAIRS > 1) ? $clog2(c_NUM_PAIRS) : 1;
    localparam int c_OBJ_W     = $clog2(NUM_OBJ);
    localparam int c_CNT_W     = $clog2(FIFO_DEPTH + 1);
    localparam int c_PTR_W     = $clog2(FIFO_DEPTH);

    // Pair decode
    logic [c_NUM_PAIRS-1:0] w_hit;
    logic [c_OBJ_W-1:0]     w_pair_a [c_NUM_PAIRS];
    logic [c_OBJ_W-1:0]     w_pair_b [c_NUM_PAIRS];

    // Frame bookkeeping
    logic [c_NUM_PAIRS-1:0] r_seen;
    logic [c_NUM_PAIRS-1:0] r_pending;
    logic [c_NUM_PAIRS-1:0] r_frame_hits;
    logic                   r_frame_flag;
    logic                   r_collision;
    logic                   r_pulse;
    logic [c_NUM_PAIRS-1:0] w_seen_eff;
    logic [c_NUM_PAIRS-1:0] w_new;
    logic                   w_flag_eff;
    logic                   w_any_hit;

    // Arbiter
    logic [c_NUM_PAIRS-1:0] w_grant;
    logic [c_PAIR_W-1:0]    w_gidx;
    logic [c_OBJ_W-1:0]     w_ga;
    logic [c_OBJ_W-1:0]     w_gb;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_full;

    // FIFO storage
    logic [c_PAIR_W-1:0]    r_mem_pair [FIFO_DEPTH];
    logic [c_OBJ_W-1:0]     r_mem_a    [FIFO_DEPTH];
    logic [c_OBJ_W-1:0]     r_mem_b    [FIFO_DEPTH];
    logic [c_PTR_W-1:0]     r_wr_ptr;
    logic [c_PTR_W-1:0]     r_rd_ptr;
    logic [c_CNT_W-1:0]     r_count;

    // Enumerate unordered pairs (i<j) in row-major order of the upper triangle.
    for (genvar gi = 0; gi < NUM_OBJ; gi++) begin : g_obj_lo
        for (genvar gj = gi + 1; gj < NUM_OBJ; gj++) begin : g_obj_hi
            localparam int c_P = gi*NUM_OBJ - gi*(gi+1)/2 + (gj - gi - 1);
            assign w_hit[c_P]    = drawing_request[gi] & drawing_request[gj] & PAIR_MASK[c_P];
            assign w_pair_a[c_P] = c_OBJ_W'(gi);
            assign w_pair_b[c_P] = c_OBJ_W'(gj);
        end
    end

    // A startOfFrame cycle sees an empty history, so its hits count for the new frame.
    assign w_seen_eff = startOfFrame ? '0 : r_seen;
    assign w_flag_eff = startOfFrame ? 1'b0 : r_frame_flag;
    assign w_any_hit  = |w_hit;
    assign w_new      = w_hit & ~w_seen_eff;

    assign w_full = (r_count == c_CNT_W'(FIFO_DEPTH));
    assign w_pop  = evt_valid & evt_ready;

    // Fixed-priority grant: lowest pending pair index wins whenever the FIFO has room.
    always_comb begin
        w_grant = '0;
        w_gidx  = '0;
        w_ga    = '0;
        w_gb    = '0;
        w_push  = (|r_pending) & ~w_full;
        for (int k = c_NUM_PAIRS - 1; k >= 0; k--) begin
            if (r_pending[k]) begin
                w_grant    = '0;
                w_grant[k] = w_push;
                w_gidx     = c_PAIR_W'(k);
                w_ga       = w_pair_a[k];
                w_gb       = w_pair_b[k];
            end
        end
    end

    // Per-frame state: collision flags, once-per-frame tracking and pending events.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_collision  <= 1'b0;
            r_pulse      <= 1'b0;
            r_frame_flag <= 1'b0;
            r_seen       <= '0;
            r_pending    <= '0;
            r_frame_hits <= '0;
        end else begin
            r_collision  <= w_any_hit;
            r_pulse      <= w_any_hit & ~w_flag_eff;
            r_frame_flag <= w_flag_eff | w_any_hit;
            r_seen       <= w_seen_eff | w_hit;
            r_pending    <= (r_pending & ~w_grant) | w_new;
            if (startOfFrame) begin
                r_frame_hits <= r_seen;
            end
        end
    end

    // FIFO pointers and occupancy; a full FIFO refuses a push even if it pops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO payload storage; contents are only meaningful below the occupancy count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_pair[r_wr_ptr] <= w_gidx;
            r_mem_a[r_wr_ptr]    <= w_ga;
            r_mem_b[r_wr_ptr]    <= w_gb;
        end
    end

    assign collision      = r_collision;
    assign SingleHitPulse = r_pulse;
    assign frame_hits     = r_frame_hits;
    assign evt_valid      = (r_count != '0);
    assign evt_pair       = r_mem_pair[r_rd_ptr];
    assign evt_obj_a      = r_mem_a[r_rd_ptr];
    assign evt_obj_b      = r_mem_b[r_rd_ptr];
    assign evt_count      = r_count;

endmodule
`default_nettype wire

// File: tb/tb_collision_event_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_collision_event_arbiter
//  Description : Directed self-checking bench for collision_event_arbiter
//                (NUM_OBJ=4, FIFO_DEPTH=8; second instance with a pair mask).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_collision_event_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       sof;
    logic [3:0] req;
    logic       ready;

    logic       collision, pulse, evt_valid;
    logic [5:0] frame_hits;
    logic [2:0] evt_pair;
    logic [1:0] evt_a, evt_b;
    logic [3:0] evt_count;

    logic       m_collision, m_pulse, m_evt_valid;
    logic [5:0] m_frame_hits;
    logic [2:0] m_evt_pair;
    logic [1:0] m_evt_a, m_evt_b;
    logic [3:0] m_evt_count;

    int n_checks = 0;
    int n_fail   = 0;
    int q_pair[$];
    int q_a[$];
    int q_b[$];
    int pulses;

    collision_event_arbiter #(.NUM_OBJ(4), .FIFO_DEPTH(8), .PAIR_MASK(6'b111111)) dut (
        .clk(clk), .reset(reset), .startOfFrame(sof), .drawing_request(req),
        .collision(collision), .SingleHitPulse(pulse), .frame_hits(frame_hits),
        .evt_valid(evt_valid), .evt_ready(ready), .evt_pair(evt_pair),
        .evt_obj_a(evt_a), .evt_obj_b(evt_b), .evt_count(evt_count)
    );

    collision_event_arbiter #(.NUM_OBJ(4), .FIFO_DEPTH(8), .PAIR_MASK(6'b111110)) dut_m (
        .clk(clk), .reset(reset), .startOfFrame(sof), .drawing_request(req),
        .collision(m_collision), .SingleHitPulse(m_pulse), .frame_hits(m_frame_hits),
        .evt_valid(m_evt_valid), .evt_ready(ready), .evt_pair(m_evt_pair),
        .evt_obj_a(m_evt_a), .evt_obj_b(m_evt_b), .evt_count(m_evt_count)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1; sof = 1'b0; req = 4'b0000; ready = 1'b0;
        tick; tick;
        reset = 1'b0;
    endtask

    task automatic clear_log;
        q_pair.delete(); q_a.delete(); q_b.delete(); pulses = 0;
    endtask

    // Record every head that is accepted, one per cycle, for n cycles.
    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            if (evt_valid && ready) begin
                q_pair.push_back(int'(evt_pair)); q_a.push_back(int'(evt_a)); q_b.push_back(int'(evt_b));
            end
            if (pulse) pulses++;
            tick;
        end
    endtask

    task automatic test_reset;
        do_reset;
        n_checks++; if (collision !== 1'b0) begin n_fail++; $display("FAIL reset_collision: got %b expected 0", collision); end
        n_checks++; if (pulse !== 1'b0) begin n_fail++; $display("FAIL reset_pulse: got %b expected 0", pulse); end
        n_checks++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", evt_valid); end
        n_checks++; if (evt_count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", evt_count); end
        n_checks++; if (frame_hits !== 6'b0) begin n_fail++; $display("FAIL reset_frame_hits: got %b expected 0", frame_hits); end
    endtask

    task automatic test_single_hit;
        do_reset;
        req = 4'b0011; tick; req = 4'b0000;
        n_checks++; if (collision !== 1'b1) begin n_fail++; $display("FAIL single_collision: got %b expected 1", collision); end
        n_checks++; if (pulse !== 1'b1) begin n_fail++; $display("FAIL single_pulse: got %b expected 1", pulse); end
        n_checks++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_early: got %b expected 0", evt_valid); end
        tick;
        n_checks++; if (evt_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b expected 1", evt_valid); end
        n_checks++; if (evt_pair !== 3'd0) begin n_fail++; $display("FAIL single_pair: got %0d expected 0", evt_pair); end
        n_checks++; if (evt_a !== 2'd0 || evt_b !== 2'd1) begin n_fail++; $display("FAIL single_objs: got %0d/%0d expected 0/1", evt_a, evt_b); end
        n_checks++; if (evt_count !== 4'd1) begin n_fail++; $display("FAIL single_count: got %0d expected 1", evt_count); end
        n_checks++; if (collision !== 1'b0 || pulse !== 1'b0) begin n_fail++; $display("FAIL single_drop: got %b/%b expected 0/0", collision, pulse); end
        ready = 1'b1; tick; ready = 1'b0;
        n_checks++; if (evt_count !== 4'd0) begin n_fail++; $display("FAIL single_pop: got %0d expected 0", evt_count); end
    endtask

    task automatic test_multi_pair;
        int exp_p[3] = '{0, 1, 3};
        int exp_a[3] = '{0, 0, 1};
        int exp_b[3] = '{1, 2, 2};
        do_reset;
        clear_log;
        ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            req = (c < 3) ? 4'b0111 : 4'b0000;
            if (evt_valid) begin
                q_pair.push_back(int'(evt_pair)); q_a.push_back(int'(evt_a)); q_b.push_back(int'(evt_b));
            end
            if (pulse) pulses++;
            tick;
        end
        ready = 1'b0;
        n_checks++; if (q_pair.size() != 3) begin n_fail++; $display("FAIL multi_event_count: got %0d expected 3", q_pair.size()); end
        n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL multi_pulse_count: got %0d expected 1", pulses); end
        if (q_pair.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (q_pair[i] != exp_p[i] || q_a[i] != exp_a[i] || q_b[i] != exp_b[i]) begin
                    n_fail++;
                    $display("FAIL multi_event%0d: got p%0d(%0d,%0d) expected p%0d(%0d,%0d)",
                             i, q_pair[i], q_a[i], q_b[i], exp_p[i], exp_a[i], exp_b[i]);
                end
            end
        end
    endtask

    task automatic test_frame_summary;
        do_reset;
        ready = 1'b1;
        for (int f = 0; f < 2; f++) begin
            sof = 1'b1; tick; sof = 1'b0;
            if (f == 1) begin
                n_checks++; if (frame_hits !== 6'b100001) begin n_fail++; $display("FAIL frame_hits: got %b expected 100001", frame_hits); end
            end else begin
                n_checks++; if (frame_hits !== 6'b000000) begin n_fail++; $display("FAIL frame_hits_first: got %b expected 000000", frame_hits); end
            end
            req = 4'b0011; tick;
            n_checks++; if (pulse !== 1'b1) begin n_fail++; $display("FAIL frame%0d_first_pulse: got %b expected 1", f, pulse); end
            req = 4'b1100; tick; req = 4'b0000;
            n_checks++; if (pulse !== 1'b0) begin n_fail++; $display("FAIL frame%0d_second_pulse: got %b expected 0", f, pulse); end
            clear_log;
            drain(8);
            n_checks++;
            if (q_pair.size() != 2) begin
                n_fail++; $display("FAIL frame%0d_events: got %0d events expected 2", f, q_pair.size());
            end else if (q_pair[0] != 0 || q_pair[1] != 5 || q_a[1] != 2 || q_b[1] != 3) begin
                n_fail++; $display("FAIL frame%0d_events: got p%0d,p%0d(%0d,%0d) expected p0,p5(2,3)", f, q_pair[0], q_pair[1], q_a[1], q_b[1]);
            end
        end
        ready = 1'b0;
    endtask

    task automatic test_back_pressure;
        do_reset;
        req = 4'b1111; tick; req = 4'b0000;
        repeat (10) tick;
        n_checks++; if (evt_count !== 4'd6) begin n_fail++; $display("FAIL bp_count_frame1: got %0d expected 6", evt_count); end
        sof = 1'b1; tick; sof = 1'b0;
        req = 4'b1111; tick; req = 4'b0000;
        repeat (10) tick;
        n_checks++; if (evt_count !== 4'd8) begin n_fail++; $display("FAIL bp_count_full: got %0d expected 8", evt_count); end
        n_checks++; if (evt_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_held: got %b expected 1", evt_valid); end
        n_checks++; if (evt_pair !== 3'd0) begin n_fail++; $display("FAIL bp_head_stable: got %0d expected 0", evt_pair); end
        clear_log;
        ready = 1'b1;
        drain(30);
        ready = 1'b0;
        n_checks++; if (q_pair.size() != 12) begin n_fail++; $display("FAIL bp_total: got %0d expected 12", q_pair.size()); end
        if (q_pair.size() == 12) begin
            for (int i = 0; i < 12; i++) begin
                n_checks++;
                if (q_pair[i] != (i % 6)) begin n_fail++; $display("FAIL bp_order%0d: got p%0d expected p%0d", i, q_pair[i], i % 6); end
            end
        end
        n_checks++; if (evt_count !== 4'd0) begin n_fail++; $display("FAIL bp_empty: got %0d expected 0", evt_count); end
    endtask

    task automatic test_mask;
        do_reset;
        req = 4'b0011; tick; req = 4'b0000;
        n_checks++; if (collision !== 1'b1) begin n_fail++; $display("FAIL mask_ref_collision: got %b expected 1", collision); end
        n_checks++; if (m_collision !== 1'b0) begin n_fail++; $display("FAIL mask_collision: got %b expected 0", m_collision); end
        n_checks++; if (m_pulse !== 1'b0) begin n_fail++; $display("FAIL mask_pulse: got %b expected 0", m_pulse); end
        repeat (3) tick;
        n_checks++; if (m_evt_valid !== 1'b0 || m_evt_count !== 4'd0) begin n_fail++; $display("FAIL mask_event: got valid %b count %0d expected 0/0", m_evt_valid, m_evt_count); end
        req = 4'b0101; tick; req = 4'b0000;
        n_checks++; if (m_collision !== 1'b1 || m_pulse !== 1'b1) begin n_fail++; $display("FAIL mask_enabled_pair: got %b/%b expected 1/1", m_collision, m_pulse); end
        tick;
        n_checks++; if (m_evt_valid !== 1'b1 || m_evt_pair !== 3'd1) begin n_fail++; $display("FAIL mask_enabled_event: got valid %b pair %0d expected 1/1", m_evt_valid, m_evt_pair); end
    endtask

    task automatic test_reset_flush;
        int stale;
        do_reset;
        req = 4'b1111; tick; req = 4'b0000;
        sof = 1'b1; tick; sof = 1'b0;
        tick; tick;
        n_checks++; if (evt_count !== 4'd3) begin n_fail++; $display("FAIL flush_pre_count: got %0d expected 3", evt_count); end
        n_checks++; if (frame_hits !== 6'b111111) begin n_fail++; $display("FAIL flush_pre_hits: got %b expected 111111", frame_hits); end
        reset = 1'b1; #1;
        n_checks++; if (evt_valid !== 1'b0 || evt_count !== 4'd0) begin n_fail++; $display("FAIL flush_fifo: got valid %b count %0d expected 0/0", evt_valid, evt_count); end
        n_checks++; if (frame_hits !== 6'b0) begin n_fail++; $display("FAIL flush_hits: got %b expected 0", frame_hits); end
        tick;
        reset = 1'b0; ready = 1'b1;
        stale = 0;
        for (int i = 0; i < 10; i++) begin
            if (evt_valid) stale++;
            tick;
        end
        ready = 1'b0;
        n_checks++; if (stale != 0) begin n_fail++; $display("FAIL flush_stale: got %0d events expected 0", stale); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; sof = 1'b0; req = 4'b0000; ready = 1'b0;
        test_reset;
        test_single_hit;
        test_multi_pair;
        test_frame_summary;
        test_back_pressure;
        test_mask;
        test_reset_flush;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
